regfile_write_scheduler: RTL and testbench

- Owns the single write port of the 15-entry register file (R0–R14; R15 is the externally supplied PC).
- Arbitrates round-robin between the ALU writeback and memory-load writeback requesters.
- Redirects R15 destinations to a PC-write output.
- Keeps a per-register pending-write scoreboard, so decode can detect RAW hazards on its two read selectors.

---
 rtl/regfile_write_scheduler_pkg.sv | 13 +
 rtl/regfile_write_scheduler_if.sv | 44 ++++
 rtl/regfile_write_scheduler_rr_arbiter2.sv | 28 ++
 rtl/regfile_write_scheduler.sv | 109 ++++++++++
 tb/tb_regfile_write_scheduler.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_write_scheduler_pkg.sv
// Shared constants and types for the register-file write scheduler.
// Register 15 is the PC and is never tracked by the pending-write scoreboard.
package regfile_sched_pkg;

   localparam logic [3:0] REG_PC    = 4'hF;
   localparam int         NUM_GPR   = 15;
   localparam int         CNT_W_DEF = 2;

   typedef enum logic {REQ_ALU, REQ_MEM} req_e;

   typedef logic [CNT_W_DEF-1:0] cnt_arr_t [NUM_GPR];

endpackage

// File: rtl/regfile_write_scheduler_if.sv
// Requester, reservation, hazard-query and register-file write signals of the scheduler.
// The slave modport is the scheduler; the master modport is its environment.
interface regfile_write_scheduler_if #(parameter int DATA_W = 32);

   logic              alu_valid;
   logic [3:0]        alu_sel;
   logic [DATA_W-1:0] alu_data;
   logic              alu_ready;

   logic              mem_valid;
   logic [3:0]        mem_sel;
   logic [DATA_W-1:0] mem_data;
   logic              mem_ready;

   logic              rf_we;
   logic [3:0]        rf_sel;
   logic [DATA_W-1:0] rf_data;
   logic              pc_we;
   logic [DATA_W-1:0] pc_data;

   logic              rsv_valid;
   logic [3:0]        rsv_sel;
   logic              rsv_ready;

   logic [3:0]        rd_sel1;
   logic [3:0]        rd_sel2;
   logic              hazard1;
   logic              hazard2;

   modport master (
      output alu_valid, alu_sel, alu_data, mem_valid, mem_sel, mem_data,
             rsv_valid, rsv_sel, rd_sel1, rd_sel2,
      input  alu_ready, mem_ready, rsv_ready, hazard1, hazard2,
             rf_we, rf_sel, rf_data, pc_we, pc_data
   );

   modport slave (
      input  alu_valid, alu_sel, alu_data, mem_valid, mem_sel, mem_data,
             rsv_valid, rsv_sel, rd_sel1, rd_sel2,
      output alu_ready, mem_ready, rsv_ready, hazard1, hazard2,
             rf_we, rf_sel, rf_data, pc_we, pc_data
   );

endinterface

// File: rtl/regfile_write_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter between ALU and load writeback.
// On a conflict the requester that did not win last time is granted.
module rr_arbiter2
   import regfile_sched_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic req_alu,
   input  logic req_mem,
   output logic gnt_alu,
   output logic gnt_mem
);

   req_e last_q;

   always_comb begin
      gnt_alu = !rst && req_alu && (!req_mem || last_q == REQ_MEM);
      gnt_mem = !rst && req_mem && (!req_alu || last_q == REQ_ALU);
   end

   // NOTE: flops are written with <= so every always_ff samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst)          last_q <= REQ_MEM;
      else if (gnt_alu) last_q <= REQ_ALU;
      else if (gnt_mem) last_q <= REQ_MEM;
   end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Single write port owner for R0-R14 plus PC redirect, with a per-register
// pending-write scoreboard that drives decode's RAW hazard flags.
module regfile_write_scheduler
   import regfile_sched_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   regfile_write_scheduler_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic              gnt_alu;
   logic              gnt_mem;
   logic              gnt;
   logic [3:0]        wsel;
   logic [DATA_W-1:0] wdata;
   logic              rsv_take;

   logic [CNT_W-1:0]   cnt_q [NUM_GPR];
   logic [15:0]        pend;
   logic [15:0]        full;
   logic [NUM_GPR-1:0] inc;
   logic [NUM_GPR-1:0] dec;

   logic              rf_we_q;
   logic [3:0]        rf_sel_q;
   logic [DATA_W-1:0] rf_data_q;
   logic              pc_we_q;
   logic [DATA_W-1:0] pc_data_q;

   rr_arbiter2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .req_alu (bus.alu_valid),
      .req_mem (bus.mem_valid),
      .gnt_alu (gnt_alu),
      .gnt_mem (gnt_mem)
   );

   assign gnt           = gnt_alu | gnt_mem;
   assign wsel          = gnt_mem ? bus.mem_sel  : bus.alu_sel;
   assign wdata         = gnt_mem ? bus.mem_data : bus.alu_data;
   assign bus.alu_ready = gnt_alu;
   assign bus.mem_ready = gnt_mem;

   // NOTE: defaults first so every path through the block assigns; no latches.
   always_comb begin
      pend = '0;
      full = '0;
      inc  = '0;
      dec  = '0;
      for (int i = 0; i < NUM_GPR; i++) begin
         pend[i] = (cnt_q[i] != '0);
         full[i] = (cnt_q[i] == CNT_MAX);
         inc[i]  = rsv_take && (bus.rsv_sel == 4'(i));
         dec[i]  = gnt && (wsel == 4'(i));
      end
   end

   // Bit 15 of pend/full is tied low, so the PC is never busy nor full.
   assign bus.rsv_ready = !rst && !full[bus.rsv_sel];
   assign rsv_take      = bus.rsv_valid && bus.rsv_ready;
   assign bus.hazard1   = pend[bus.rd_sel1];
   assign bus.hazard2   = pend[bus.rd_sel2];

   // NOTE: the counter array is state that hazards read directly, so every entry is reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_GPR; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_GPR; i++) begin
            case ({inc[i], dec[i]})
               2'b10:   cnt_q[i] <= cnt_q[i] + CNT_W'(1);
               2'b01:   if (cnt_q[i] != '0) cnt_q[i] <= cnt_q[i] - CNT_W'(1);
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rf_we_q   <= 1'b0;
         pc_we_q   <= 1'b0;
         rf_sel_q  <= '0;
         rf_data_q <= '0;
         pc_data_q <= '0;
      end else begin
         rf_we_q <= gnt && (wsel != REG_PC);
         pc_we_q <= gnt && (wsel == REG_PC);
         if (gnt && wsel != REG_PC) begin
            rf_sel_q  <= wsel;
            rf_data_q <= wdata;
         end
         if (gnt && wsel == REG_PC) pc_data_q <= wdata;
      end
   end

   assign bus.rf_we   = rf_we_q;
   assign bus.rf_sel  = rf_sel_q;
   assign bus.rf_data = rf_data_q;
   assign bus.pc_we   = pc_we_q;
   assign bus.pc_data = pc_data_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Scoreboard bench for regfile_write_scheduler: directed scenarios then random traffic,
// checked against a behavioural model of arbitration, writes and pending counts.
module tb_regfile_write_scheduler;
   import regfile_sched_pkg::*;

   localparam int DW   = 32;
   localparam int MAXC = 3;

   typedef struct {
      bit rst;
      bit av; logic [3:0] as; logic [31:0] ad;
      bit mv; logic [3:0] ms; logic [31:0] md;
      bit rv; logic [3:0] rs;
      logic [3:0] r1; logic [3:0] r2;
   } stim_t;

   typedef struct {
      int          cyc;
      bit          rf_we;
      logic [3:0]  rf_sel;
      logic [31:0] rf_data;
      bit          pc_we;
      logic [31:0] pc_data;
   } out_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   regfile_write_scheduler_if #(.DATA_W(DW)) bus ();

   regfile_write_scheduler #(.DATA_W(DW), .CNT_W(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   out_t        exp_q[$];
   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   int          cnt [NUM_GPR];
   bit          last_alu = 1'b0;
   logic [3:0]  sh_sel  = '0;
   logic [31:0] sh_data = '0;
   logic [31:0] sh_pc   = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic stim_t mk(bit av, logic [3:0] as, logic [31:0] ad,
                                bit mv, logic [3:0] ms, logic [31:0] md,
                                bit rv, logic [3:0] rs, logic [3:0] r1, logic [3:0] r2, bit r);
      stim_t s;
      s.av = av; s.as = as; s.ad = ad;
      s.mv = mv; s.ms = ms; s.md = md;
      s.rv = rv; s.rs = rs; s.r1 = r1; s.r2 = r2; s.rst = r;
      return s;
   endfunction

   // One cycle: drive, check combinational answers mid-cycle, advance the model.
   task automatic step(input stim_t s, output bit ga, output bit gm);
      out_t        o;
      bit          racc;
      logic [3:0]  ws;
      logic [31:0] wd;
      rst           = s.rst;
      bus.alu_valid = s.av; bus.alu_sel = s.as; bus.alu_data = s.ad;
      bus.mem_valid = s.mv; bus.mem_sel = s.ms; bus.mem_data = s.md;
      bus.rsv_valid = s.rv; bus.rsv_sel = s.rs;
      bus.rd_sel1   = s.r1; bus.rd_sel2 = s.r2;
      @(negedge clk);
      ga = 1'b0; gm = 1'b0;
      if (!s.rst) begin
         if (s.av && s.mv) begin
            if (last_alu) gm = 1'b1; else ga = 1'b1;
         end else begin
            ga = s.av; gm = s.mv;
         end
      end
      racc = !s.rst && ((s.rs == 4'hF) || (cnt[s.rs] < MAXC));
      check("alu_ready", bus.alu_ready, ga);
      check("mem_ready", bus.mem_ready, gm);
      check("rsv_ready", bus.rsv_ready, racc);
      check("hazard1", bus.hazard1, (s.r1 != 4'hF) && (cnt[s.r1] != 0));
      check("hazard2", bus.hazard2, (s.r2 != 4'hF) && (cnt[s.r2] != 0));
      o.cyc = cyc + 1;
      o.rf_we = 1'b0;
      o.pc_we = 1'b0;
      if (s.rst) begin
         foreach (cnt[i]) cnt[i] = 0;
         last_alu = 1'b0;
         sh_sel = '0; sh_data = '0; sh_pc = '0;
      end else begin
         if (s.rv && racc && s.rs != 4'hF) cnt[s.rs]++;
         if (ga || gm) begin
            ws = ga ? s.as : s.ms;
            wd = ga ? s.ad : s.md;
            last_alu = ga;
            if (ws == 4'hF) begin
               sh_pc   = wd;
               o.pc_we = 1'b1;
            end else begin
               sh_sel  = ws;
               sh_data = wd;
               o.rf_we = 1'b1;
               if (cnt[ws] > 0) cnt[ws]--;
            end
         end
      end
      o.rf_sel = sh_sel; o.rf_data = sh_data; o.pc_data = sh_pc;
      exp_q.push_back(o);
      @(posedge clk);
      #1;
   endtask

   // Monitor: compares registered write outputs against the expectation due this cycle.
   initial begin
      out_t o;
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            check("sb_order", exp_q[0].cyc, cyc);
            void'(exp_q.pop_front());
         end
         if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            o = exp_q.pop_front();
            check("rf_we", bus.rf_we, o.rf_we);
            check("rf_sel", bus.rf_sel, o.rf_sel);
            check("rf_data", bus.rf_data, o.rf_data);
            check("pc_we", bus.pc_we, o.pc_we);
            check("pc_data", bus.pc_data, o.pc_data);
         end
      end
   end

   function automatic logic [3:0] pick();
      int r = $urandom_range(0, 5);
      return (r == 5) ? 4'hF : 4'(4 + r);
   endfunction

   initial begin
      stim_t       s;
      bit          ga, gm, ap, mp;
      logic [3:0]  as, ms;
      logic [31:0] ad, md;
      foreach (cnt[i]) cnt[i] = 0;
      bus.alu_valid = 0; bus.alu_sel = 0; bus.alu_data = 0;
      bus.mem_valid = 0; bus.mem_sel = 0; bus.mem_data = 0;
      bus.rsv_valid = 0; bus.rsv_sel = 0;
      bus.rd_sel1 = 4'hF; bus.rd_sel2 = 4'hF;
      @(posedge clk);
      #1;

      // reset, then a single ALU write to R3
      step(mk(0,0,0, 0,0,0, 0,0, 4'hF,4'hF, 1), ga, gm);
      step(mk(0,0,0, 0,0,0, 0,0, 4'hF,4'hF, 1), ga, gm);
      step(mk(1,4'd3,32'h12345678, 0,0,0, 0,0, 4'hF,4'hF, 0), ga, gm);
      step(mk(0,0,0, 0,0,0, 0,0, 4'hF,4'hF, 0), ga, gm);
      step(mk(0,0,0, 0,0,0, 0,0, 4'hF,4'hF, 0), ga, gm);

      // conflict sequence after reset: ALU, MEM, ALU
      step(mk(0,0,0, 0,0,0, 0,0, 4'hF,4'hF, 1), ga, gm);
      step(mk(1,4'd1,32'hA0000001, 1,4'd2,32'hB0000002, 0,0, 4'hF,4'hF, 0), ga, gm);
      step(mk(1,4'd1,32'hA0000011, 1,4'd2,32'hB0000002, 0,0, 4'hF,4'hF, 0), ga, gm);
      step(mk(1,4'd1,32'hA0000011, 1,4'd2,32'hB0000022, 0,0, 4'hF,4'hF, 0), ga, gm);

      // PC redirect
      step(mk(1,4'hF,32'h00000100, 0,0,0, 0,0, 4'd1,4'd2, 0), ga, gm);
      step(mk(0,0,0, 0,0,0, 0,0, 4'd1,4'd2, 0), ga, gm);

      // fill R5, refuse the fourth, drain with three writes
      for (int i = 0; i < 4; i++) step(mk(0,0,0, 0,0,0, 1,4'd5, 4'd5,4'hF, 0), ga, gm);
      for (int i = 0; i < 3; i++) step(mk(1,4'd5,32'h55550000 + i, 0,0,0, 0,0, 4'd5,4'hF, 0), ga, gm);
      step(mk(0,0,0, 0,0,0, 0,0, 4'd5,4'hF, 0), ga, gm);

      // simultaneous reserve and write on R7 with count 1; PC read never hazards
      step(mk(0,0,0, 0,0,0, 1,4'd7, 4'd7,4'hF, 0), ga, gm);
      step(mk(1,4'd7,32'h77777777, 0,0,0, 1,4'd7, 4'd7,4'hF, 0), ga, gm);
      step(mk(0,0,0, 0,0,0, 1,4'hF, 4'd7,4'hF, 0), ga, gm);

      // R9 at max: reservation refused even while a write to R9 is granted
      for (int i = 0; i < 3; i++) step(mk(0,0,0, 0,0,0, 1,4'd9, 4'd9,4'd7, 0), ga, gm);
      step(mk(0,0,0, 1,4'd9,32'h99999999, 1,4'd9, 4'd9,4'd7, 0), ga, gm);
      step(mk(0,0,0, 0,0,0, 0,0, 4'd9,4'd7, 0), ga, gm);

      // write to an idle register saturates its count at zero
      step(mk(1,4'd10,32'h0A0A0A0A, 0,0,0, 0,0, 4'd10,4'hF, 0), ga, gm);
      step(mk(0,0,0, 0,0,0, 1,4'd10, 4'd10,4'hF, 0), ga, gm);
      step(mk(0,0,0, 0,0,0, 0,0, 4'd10,4'hF, 0), ga, gm);

      // reset in a grant cycle drops the write; first conflict afterwards goes to ALU
      step(mk(1,4'd4,32'h44444444, 1,4'd6,32'h66666666, 1,4'd3, 4'd7,4'd9, 1), ga, gm);
      step(mk(1,4'd4,32'h44444444, 1,4'd6,32'h66666666, 0,0, 4'd7,4'd9, 0), ga, gm);
      step(mk(0,0,0, 1,4'd6,32'h66666666, 0,0, 4'd7,4'd9, 0), ga, gm);

      // randomized traffic
      ap = 0; mp = 0; as = 0; ms = 0; ad = 0; md = 0;
      for (int n = 0; n < 1500; n++) begin
         if (!ap && $urandom_range(0, 2) != 0) begin
            ap = 1; as = pick(); ad = $urandom;
         end
         if (!mp && $urandom_range(0, 2) != 0) begin
            mp = 1; ms = pick(); md = $urandom;
         end
         s = mk(ap, as, ad, mp, ms, md, 1'($urandom_range(0, 1)), pick(),
                pick(), pick(), ($urandom_range(0, 63) == 0));
         step(s, ga, gm);
         if (ga) ap = 0;
         if (gm) mp = 0;
      end

      step(mk(0,0,0, 0,0,0, 0,0, 4'hF,4'hF, 0), ga, gm);
      @(negedge clk);
      @(posedge clk);
      #1;
      check("sb_drain", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
